cdc_handshake_source: RTL

- Source-side controller of a req/ack clock-domain-crossing handshake, running entirely in the sending clock domain.
- Captures one data word, holds it stable on data_o, and emits a one-cycle req_pulse_o toward a flag_synchronizer that crosses to the destination domain.
- Waits for the returning ack pulse, which arrives through a second flag_synchronizer, then enforces a guard gap before accepting the next word.
- Provides a timeout and stray-ack detection so that a dead or slow destination cannot hang the source.

---
 rtl/cdc_pkg.sv | 19 +
 rtl/cdc_down_counter.sv | 28 ++
 rtl/cdc_handshake_source.sv | 114 +++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the source side of the req/ack CDC handshake.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT_ACK,
    GUARD
  } hs_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int DEFAULT_GUARD_CYCLES   = 4;

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cdc_down_counter.sv
// Loadable down counter that saturates at zero and flags when it sits there.
module cdc_down_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cdc_handshake_source.sv
// Source-domain controller: captures a word, pulses req, waits for ack or
// timeout, then holds off for a guard gap before accepting the next word.
module cdc_handshake_source
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GUARD_CYCLES   = DEFAULT_GUARD_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  req_pulse_o,
  input  logic                  ack_pulse_i,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic                  stray_ack_o,
  input  logic                  clear_i
);

  localparam int TIMEOUT_W = cnt_width(TIMEOUT_CYCLES);
  localparam int GUARD_W   = cnt_width(GUARD_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  // Down counters load N-1 so the zero flag marks the Nth cycle in the state.
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD =
    TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD =
    GUARD_W'((GUARD_CYCLES < 1) ? 0 : GUARD_CYCLES - 1);

  hs_state_t state;

  logic timeout_zero;
  logic guard_zero;
  logic timeout_hit;
  logic leave_wait;

  assign timeout_hit = TIMEOUT_EN && (state == WAIT_ACK) && timeout_zero && !ack_pulse_i;
  assign leave_wait  = (state == WAIT_ACK) && (ack_pulse_i || timeout_hit);

  cdc_down_counter #(.WIDTH(TIMEOUT_W)) u_timeout_cnt (
    .clk        (clk_i),
    .rst        (rst_i),
    .load       (state == REQUEST),
    .load_value (TIMEOUT_LOAD),
    .dec        (state == WAIT_ACK),
    .zero       (timeout_zero)
  );

  cdc_down_counter #(.WIDTH(GUARD_W)) u_guard_cnt (
    .clk        (clk_i),
    .rst        (rst_i),
    .load       (leave_wait),
    .load_value (GUARD_LOAD),
    .dec        (state == GUARD),
    .zero       (guard_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ready_o     <= 1'b1;
      data_o      <= '0;
      req_pulse_o <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      stray_ack_o <= 1'b0;
    end else begin
      req_pulse_o <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;

      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            data_o      <= data_i;
            ready_o     <= 1'b0;
            req_pulse_o <= 1'b1;
            state       <= REQUEST;
          end
        end
        REQUEST: state <= WAIT_ACK;
        WAIT_ACK: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (ack_pulse_i) begin
            done_o <= 1'b1;
            state  <= GUARD;
          end else if (timeout_hit) begin
            timeout_o <= 1'b1;
            state     <= GUARD;
          end
        end
        GUARD: begin
          if (guard_zero) begin
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Set wins over clear so a stray ack is never lost.
      if (ack_pulse_i && (state != WAIT_ACK)) begin
        stray_ack_o <= 1'b1;
      end else if (clear_i) begin
        stray_ack_o <= 1'b0;
      end
    end
  end

endmodule
